// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// The slave modport is the loader. The master modport is the host link plus the memory side.
interface imem_loader_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic                   start;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   byte_ready;
  logic                   we;
  logic [INS_ADDRESS-1:0] wa;
  logic [INS_W-1:0]       wd;
  logic                   cpu_hold;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, we, wa, wd, cpu_hold, busy, done, err
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, we, wa, wd, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory. It takes a length-prefixed, XOR-checksummed byte
// stream, packs bytes into little-endian words and writes them from address 0 upward.
module imem_loader #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam int          AW    = INS_ADDRESS - 2;
  localparam int          DEPTH = 2 ** AW;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR
  } state_t;

  state_t                 state, state_nx;
  logic [7:0]             len_lo;
  logic [15:0]            n_words;
  logic [AW-1:0]          word_idx;
  logic [1:0]             byte_idx;
  logic [7:0]             csum;
  logic [23:0]            word_buf;
  logic                   we_r;
  logic [INS_ADDRESS-1:0] wa_r;
  logic [INS_W-1:0]       wd_r;

  logic        active;
  logic        accept;
  logic        start_ok;
  logic [15:0] len_nx;
  logic        last_word;

  assign active    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign accept    = bus.byte_valid && active;
  assign start_ok  = bus.start && !active;
  assign len_nx    = {bus.byte_data, len_lo};
  assign last_word = ({{(16-AW){1'b0}}, word_idx} == (n_words - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start_ok) state_nx = LEN0;
      LEN0: if (accept) state_nx = LEN1;
      LEN1: if (accept) begin
        if (len_nx == 16'd0 || len_nx > DEPTH_W) state_nx = ERR;
        else                                     state_nx = DATA;
      end
      DATA: if (accept && byte_idx == 2'd3 && last_word) state_nx = CSUM;
      CSUM: if (accept) state_nx = (bus.byte_data == csum) ? DONE : ERR;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: the lane-3 byte completes the word, and the write issues on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= '0;
      n_words  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      csum     <= '0;
      word_buf <= '0;
      we_r     <= 1'b0;
      wa_r     <= '0;
      wd_r     <= '0;
    end else begin
      we_r <= 1'b0;
      if (start_ok) begin
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end
      if (accept) begin
        case (state)
          LEN0: len_lo  <= bus.byte_data;
          LEN1: n_words <= len_nx;
          DATA: begin
            csum     <= csum ^ bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.byte_data;
              2'd1: word_buf[15:8]  <= bus.byte_data;
              2'd2: word_buf[23:16] <= bus.byte_data;
              default: begin
                wd_r     <= INS_W'({bus.byte_data, word_buf});
                wa_r     <= {word_idx, 2'b00};
                we_r     <= 1'b1;
                word_idx <= word_idx + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready = active;
  assign bus.busy       = active;
  assign bus.cpu_hold   = active || (state == ERR);
  assign bus.done       = (state == DONE);
  assign bus.err        = (state == ERR);
  assign bus.we         = we_r;
  assign bus.wa         = wa_r;
  assign bus.wd         = wd_r;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. A table of complete streams is followed by hand-written
// sequences for reset, latency, gaps and full capacity.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  imem_loader_if #(.INS_ADDRESS(9), .INS_W(32)) bus ();
  imem_loader #(.INS_ADDRESS(9), .INS_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  always @(negedge clk) if (rst_n && bus.we) begin
    wa_q.push_back(32'(bus.wa));
    wd_q.push_back(bus.wd);
  end

  typedef struct {
    logic [7:0]  b [12];
    int          nb;
    int          nw;
    logic [31:0] wd [2];
    logic        dn, er, hd;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic set_nominal(input int i, input logic [7:0] cs);
    vt[i].b  = '{8'h02, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, cs, 8'h00};
    vt[i].nb = 11; vt[i].nw = 2;
    vt[i].wd = '{32'h0000_7033, 32'h0010_0093};
  endtask

  initial begin
    int bad;
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;

    set_nominal(0, 8'hC0); vt[0].dn = 1; vt[0].er = 0; vt[0].hd = 0;
    vt[1].b = '{default: 8'h00}; vt[1].nb = 2; vt[1].nw = 0; vt[1].wd = '{0, 0};
    vt[1].dn = 0; vt[1].er = 1; vt[1].hd = 1;
    vt[2] = vt[1]; vt[2].b[0] = 8'h81;
    set_nominal(3, 8'hC1); vt[3].dn = 0; vt[3].er = 1; vt[3].hd = 1;
    vt[4].b = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 0, 0, 0, 0, 0};
    vt[4].nb = 7; vt[4].nw = 1; vt[4].wd = '{32'h1234_5678, 0};
    vt[4].dn = 1; vt[4].er = 0; vt[4].hd = 0;
    vt[5] = vt[1]; vt[5].b[1] = 8'h01;

    // Reset state
    #22;
    chk("rst_ready", 32'(bus.byte_ready), 0);
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_flags", {28'd0, bus.busy, bus.cpu_hold, bus.done, bus.err}, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_ready", 32'(bus.byte_ready), 0);

    // Start timing plus write latency; the last write overlaps the first CSUM cycle
    clear_q();
    pulse_start();
    chk("start_busy", {29'd0, bus.busy, bus.byte_ready, bus.cpu_hold}, 32'h7);
    send(8'h02); send(8'h00); send(8'h33); send(8'h70); send(8'h00); send(8'h00);
    chk("lat_we", 32'(bus.we), 1);
    chk("lat_wa", 32'(bus.wa), 32'h000);
    chk("lat_wd", bus.wd, 32'h0000_7033);
    tick();
    chk("we_one_cycle", 32'(bus.we), 0);
    chk("wd_hold", bus.wd, 32'h0000_7033);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    chk("last_we_csum", {30'd0, bus.we, bus.byte_ready}, 32'h3);
    chk("last_wa", 32'(bus.wa), 32'h004);
    send(8'hC0);
    chk("csum_done", {29'd0, bus.done, bus.err, bus.cpu_hold}, 32'h4);
    chk("lat_nwrites", wa_q.size(), 2);

    // Table-driven streams
    for (int v = 0; v < 6; v++) begin
      clear_q();
      pulse_start();
      chk($sformatf("v%0d_cleared", v), {30'd0, bus.done, bus.err}, 0);
      for (int k = 0; k < vt[v].nb; k++) send(vt[v].b[k]);
      tick(); tick();
      chk($sformatf("v%0d_nwrites", v), wa_q.size(), vt[v].nw);
      for (int w = 0; w < vt[v].nw; w++) begin
        chk($sformatf("v%0d_wa%0d", v, w), (w < wa_q.size()) ? wa_q[w] : 32'hDEAD_BEEF, 32'(w * 4));
        chk($sformatf("v%0d_wd%0d", v, w), (w < wd_q.size()) ? wd_q[w] : 32'hDEAD_BEEF, vt[v].wd[w]);
      end
      chk($sformatf("v%0d_result", v), {28'd0, bus.busy, bus.done, bus.err, bus.cpu_hold},
          {28'd0, 1'b0, vt[v].dn, vt[v].er, vt[v].hd});
      tick(); tick(); tick();
      chk($sformatf("v%0d_hold_kept", v), 32'(bus.cpu_hold), 32'(vt[v].hd));
    end

    // Asynchronous reset in the middle of a word
    clear_q();
    pulse_start();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {bus.wd[23:0], 3'd0, bus.we, bus.byte_ready, bus.busy, bus.cpu_hold, bus.err},
        0);
    chk("mid_rst_wa", 32'(bus.wa), 0);
    tick(); tick();
    #3 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mid_rst_nowrite", wa_q.size(), 0);
    chk("mid_rst_idle", {30'd0, bus.byte_ready, bus.busy}, 0);

    // Gapped input with a stray start during DATA
    clear_q();
    pulse_start();
    for (int k = 0; k < 11; k++) begin
      send(vt[0].b[k]);
      if (k == 5) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    tick();
    chk("gap_nwrites", wa_q.size(), 2);
    chk("gap_wd0", (wd_q.size() > 0) ? wd_q[0] : 32'hDEAD_BEEF, 32'h0000_7033);
    chk("gap_wd1", (wd_q.size() > 1) ? wd_q[1] : 32'hDEAD_BEEF, 32'h0010_0093);
    chk("gap_result", {29'd0, bus.done, bus.err, bus.cpu_hold}, 32'h4);

    // Full capacity: word i = i; XOR of 0..127 is 0
    clear_q();
    pulse_start();
    send(8'h80); send(8'h00);
    for (int i = 0; i < 128; i++) begin
      send(8'(i)); send(8'h00); send(8'h00); send(8'h00);
    end
    send(8'h00);
    tick();
    chk("full_nwrites", wa_q.size(), 128);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== 32'(i)) bad++;
    chk("full_seq_bad", bad, 0);
    chk("full_last_wa", (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 32'hDEAD_BEEF, 32'h1FC);
    chk("full_last_wd", (wd_q.size() > 0) ? wd_q[wd_q.size()-1] : 32'hDEAD_BEEF, 32'h7F);
    chk("full_result", {29'd0, bus.done, bus.err, bus.cpu_hold}, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a length-prefixed, checksummed byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words and issues one write per word to the instruction memory's write port at consecutive word-aligned byte addresses starting at 0. It sits between the host/debug byte link and the instruction memory. While loading, it holds the processor core in reset through `cpu_hold`.

## Interface
- `INS_ADDRESS`, 9: byte-address width of instruction memory; depth `DEPTH` = 2**(INS_ADDRESS-2) words (128).
- `INS_W`, 32: instruction word width; fixed at 32 (4 bytes/word).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; opens a load session.
- `byte_valid`  in  1  input byte present.
- `byte_data`  in  8  input byte.
- `byte_ready`  out  1  loader accepts byte; transfer when `byte_valid & byte_ready` at a clock edge.
- `we`  out  1  one-cycle write strobe to instruction memory.
- `wa`  out  INS_ADDRESS  byte write address, low 2 bits always 0.
- `wd`  out  INS_W  write data.
- `cpu_hold`  out  1  holds the core in reset while high.
- `busy`  out  1  session in progress.
- `done`  out  1  last session completed with good checksum.
- `err`  out  1  last session failed.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes, each word little-endian (first byte = bits 7:0), then one CSUM byte = XOR of all data bytes. Length bytes are excluded from CSUM.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `start` -> LEN0; clears `done`, `err`, word index, byte index, running XOR.
- LEN0: accept byte -> N[7:0]; -> LEN1.
- LEN1: accept byte -> N[15:8]. If N==0 or N>DEPTH -> ERR, with no writes. Otherwise -> DATA.
- DATA: each accepted byte is placed at lane byte_idx (0..3) and XORed into the checksum. On lane 3, the word is registered into `wd`, `wa`={word_idx,2'b00}, and `we` is set for the next cycle. word_idx then increments. After word N-1 -> CSUM.
- CSUM: accept byte. Match -> DONE, else -> ERR. Words already written stay in memory.
- `start` in LEN0/LEN1/DATA/CSUM is ignored.
- `byte_ready` = 1 in LEN0, LEN1, DATA, CSUM; 0 otherwise. There is no internal stall, because writes never back-pressure.
- `busy` = state in {LEN0, LEN1, DATA, CSUM}.
- `cpu_hold` = busy | (state==ERR).
- `done` = (state==DONE).
- `err` = (state==ERR).

## Timing
- Reset (async assert, any state): state=IDLE; `byte_ready`=0, `we`=0, `wa`=0, `wd`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0. A partial word is discarded. Reset release is sampled synchronously.
- `start` sampled at edge k: `busy`, `byte_ready`, `cpu_hold` go high from k+1.
- Write latency: lane-3 byte accepted at edge k gives `we`=1 in cycle k..k+1, with `wa`/`wd` valid. `we` is high exactly one cycle per word, and `wa`/`wd` hold their values afterwards.
- The last word's `we` coincides with the first CSUM cycle, so a CSUM byte can be accepted in that same cycle.
- CSUM byte accepted at edge k: `done` or `err` high from k+1. `cpu_hold` drops at k+1 on success.
- Back-to-back bytes: one per cycle at full rate. Gaps in `byte_valid` are permitted anywhere; state and indices hold.
- Address wrap is impossible, because N≤DEPTH is enforced. The last address is (DEPTH-1)×4 = 0x1FC.

## Test plan
- Reset: assert `rst_n`=0 mid-DATA (after 2 bytes of a word) -> all outputs 0 immediately; `we` never pulses for the partial word. After release, state=IDLE and `byte_ready`=0.
- Nominal 2-word load: `start`, bytes 02 00 33 70 00 00 93 00 10 00 C0 -> `we` pulses with (wa=0x000, wd=0x00007033) then (wa=0x004, wd=0x00100093); then `done`=1, `err`=0, `cpu_hold`=0.
- Length errors: N=0 (00 00) -> `err`=1 after LEN_HI with no `we`. N=129 (81 00) -> `err`=1, no `we`, `cpu_hold`=1.
- Bad checksum: same stream as nominal with CSUM=C1 -> both writes occur, then `err`=1, `done`=0, and `cpu_hold` stays 1 until the next `start`.
- Gapped input plus stray `start`: `byte_valid` toggled every other cycle, with `start` pulsed mid-DATA -> identical writes and result to the nominal load, start ignored.
- Full capacity: N=128 (80 00), words = index value -> 128 `we` pulses, last at wa=0x1FC with wd=0x0000007F; correct CSUM -> `done`=1.
